// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// fetch_sequencer_pkg : shared constants and types for the fetch sequencer
// Rev 1.0
// ==========================================================================
package fetch_sequencer_pkg;

  localparam int              PC_W   = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd2;

  localparam logic [3:0] OPC_B   = 4'hC;
  localparam logic [3:0] OPC_BR  = 4'hD;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_queue.sv
`default_nettype none
// ==========================================================================
// fetch_queue : 2-entry {instr, pc} FIFO; entry 0 is always the head
// Rev 1.0
// ==========================================================================
module fetch_queue
  import fetch_sequencer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  fq_entry_t i_entry,
  input  logic      i_pop,
  input  logic      i_flush,
  output logic [1:0] o_count,
  output logic      o_valid,
  output fq_entry_t o_head
);

  logic [1:0] r_count;
  logic       r_valid;
  fq_entry_t  r_ent0;
  fq_entry_t  r_ent1;

  logic       w_pop;
  logic [1:0] w_wr_idx;
  logic [1:0] w_count_next;

  assign w_pop        = i_pop && (r_count != 2'd0);
  assign w_wr_idx     = r_count - {1'b0, w_pop};
  assign w_count_next = i_flush ? 2'd0 : (r_count + {1'b0, i_push} - {1'b0, w_pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_valid <= 1'b0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      r_count <= w_count_next;
      r_valid <= (w_count_next != 2'd0);
      if (!i_flush) begin
        // A push landing in slot 0 overrides the shift from slot 1.
        if (w_pop) r_ent0 <= r_ent1;
        if (i_push) begin
          if (w_wr_idx == 2'd0) r_ent0 <= i_entry;
          else                  r_ent1 <= i_entry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(i_push && r_count == 2'd2));
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_ent0;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ==========================================================================
// fetch_sequencer : PC owner, imem fetch FSM, redirect/halt handling
// Option macro FETCH_SEQ_PERF_EN adds stall/squash counters.  Rev 1.0
// ==========================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [15:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [15:0] o_instr_out,
  output logic [15:0] o_instr_pc,
  input  logic        i_stall_in,
  input  logic        i_redirect_valid,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt_in,
  output logic        o_halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0] o_perf_stall_cycles,
  output logic [15:0] o_perf_squashes
`endif
);

  localparam logic [1:0] C_DEPTH = 2'(BUF_DEPTH);

  fetch_state_t r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_addr;
  logic         r_req;
  logic         r_squash;
  logic         r_halt_pend;
  logic         r_halted;

  logic         w_pop;
  logic         w_push;
  logic [1:0]   w_count;
  logic [1:0]   w_cnt_after_pop;
  logic [15:0]  w_pc_inc;
  fq_entry_t    w_head;

  assign w_pop           = o_instr_valid && !i_stall_in;
  assign w_cnt_after_pop = w_count - {1'b0, w_pop};
  assign w_pc_inc        = r_pc + PC_INC;
  assign w_push          = (r_state == WAIT) && i_imem_ready && !r_squash
                           && !i_redirect_valid && !i_halt_in;

  fetch_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry ({i_imem_rdata, r_pc}),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .o_count (w_count),
    .o_valid (o_instr_valid),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req       <= 1'b0;
      r_squash    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_redirect_valid) begin
            r_pc <= i_redirect_pc;
          end else if (i_halt_in) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (w_cnt_after_pop < C_DEPTH) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        WAIT: begin
          // imem_addr stays on the outstanding address even when pc_q is redirected.
          if (i_redirect_valid) begin
            r_pc        <= i_redirect_pc;
            r_halt_pend <= 1'b0;
            if (i_imem_ready) begin
              r_state  <= IDLE;
              r_req    <= 1'b0;
              r_squash <= 1'b0;
            end else begin
              r_squash <= 1'b1;
            end
          end else if (i_imem_ready && r_squash) begin
            r_squash    <= 1'b0;
            r_req       <= 1'b0;
            r_halt_pend <= 1'b0;
            if (r_halt_pend || i_halt_in) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (i_halt_in) begin
            if (i_imem_ready) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
              r_req    <= 1'b0;
            end else begin
              r_squash    <= 1'b1;
              r_halt_pend <= 1'b1;
            end
          end else if (i_imem_ready) begin
            r_pc <= w_pc_inc;
            if (w_cnt_after_pop < C_DEPTH - 2'd1) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        HALTED: begin
          if (i_redirect_valid) begin
            r_state  <= IDLE;
            r_halted <= 1'b0;
            r_pc     <= i_redirect_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_addr;
  assign o_instr_out = w_head.instr;
  assign o_instr_pc  = w_head.pc;
  assign o_halted    = r_halted;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_squash;
  logic        w_drop;

  assign w_drop = (r_state == WAIT) && i_imem_ready && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall  <= 16'h0000;
      r_perf_squash <= 16'h0000;
    end else begin
      if (o_instr_valid && i_stall_in && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
      if (w_drop && (r_perf_squash != 16'hFFFF))
        r_perf_squash <= r_perf_squash + 16'd1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
  assign o_perf_squashes     = r_perf_squash;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_fetch_sequencer : vector table + scoreboard bench for fetch_sequencer
// Rev 1.0
// ==========================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ready;
  logic [15:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [15:0] o_instr_out;
  logic [15:0] o_instr_pc;
  logic        i_stall_in;
  logic        i_redirect_valid;
  logic [15:0] i_redirect_pc;
  logic        i_halt_in;
  logic        o_halted;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] o_perf_stall_cycles;
  logic [15:0] o_perf_squashes;
`endif

  fetch_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ready     (i_imem_ready),
    .i_imem_rdata     (i_imem_rdata),
    .o_instr_valid    (o_instr_valid),
    .o_instr_out      (o_instr_out),
    .o_instr_pc       (o_instr_pc),
    .i_stall_in       (i_stall_in),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_halt_in        (i_halt_in),
    .o_halted         (o_halted)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .o_perf_stall_cycles (o_perf_stall_cycles),
    .o_perf_squashes     (o_perf_squashes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat = 1;
  int   wcnt = 0;
  bit   tb_squash = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, model memory, score consumed instructions.
  task automatic tick(input logic stall, input logic redir, input logic [15:0] rpc, input logic halt);
    logic rdy;
    exp_t e;
    rdy              = o_imem_req && (wcnt == lat - 1);
    i_stall_in       = stall;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_halt_in        = halt;
    i_imem_ready     = rdy;
    i_imem_rdata     = rdy ? mem_word(o_imem_addr) : 16'h0000;
    if (o_instr_valid && !stall) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got pc %h, expected no instruction", o_instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", o_instr_pc, e.pc);
        chk("sb_instr", o_instr_out, e.instr);
      end
    end
    if (redir) sb.delete();
    if (rdy) begin
      if (!(tb_squash || redir || halt)) begin
        e.instr = mem_word(o_imem_addr);
        e.pc    = o_imem_addr;
        sb.push_back(e);
      end
      tb_squash = 0;
    end else if ((redir || halt) && o_imem_req) begin
      tb_squash = 1;
    end
    if (rdy) wcnt = 0;
    else if (o_imem_req) wcnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // stall, req, addr, valid, pc : 1-cycle memory, stall held cycles 3..6
    vt[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vt[2] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vt[3] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vt[4] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vt[5] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vt[6] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vt[7] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vt[8] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004};
    vt[9] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0006};

    rst = 1'b1;
    i_imem_ready = 1'b0;
    i_imem_rdata = 16'h0000;
    i_stall_in = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 16'h0000;
    i_halt_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk1("rst_req", o_imem_req, 1'b0);
    chk("rst_addr", o_imem_addr, 16'h0000);
    chk1("rst_valid", o_instr_valid, 1'b0);
    chk("rst_instr", o_instr_out, 16'h0000);
    chk("rst_pc", o_instr_pc, 16'h0000);
    chk1("rst_halted", o_halted, 1'b0);

    for (int i = 0; i < 10; i++) begin
      chk1("vec_req", o_imem_req, vt[i].req);
      chk("vec_addr", o_imem_addr, vt[i].addr);
      chk1("vec_valid", o_instr_valid, vt[i].valid);
      if (vt[i].valid) chk("vec_pc", o_instr_pc, vt[i].pc);
      tick(vt[i].stall, 1'b0, 16'h0000, 1'b0);
    end

    // Redirect during the first wait cycle of a 3-cycle access.
    lat = 3;
    tick(1'b0, 1'b1, 16'h000F, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req && o_imem_addr == 16'h000F) break;
      chk1("redir_empty", o_instr_valid, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk1("redir_req", o_imem_req, 1'b1);
    chk("redir_addr", o_imem_addr, 16'h000F);

    // Redirect coinciding with imem_ready.
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req && wcnt == lat - 1) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    tick(1'b0, 1'b1, 16'h0040, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req) break;
      chk1("redir_rdy_novalid", o_instr_valid, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("redir_rdy_addr", o_imem_addr, 16'h0040);
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      if (o_instr_valid) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("redir_rdy_first_pc", o_instr_pc, 16'h0040);
    repeat (3) tick(1'b0, 1'b0, 16'h0000, 1'b0);

    // Halt while an access is outstanding, then leave HALTED by redirect.
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    lat = 3;
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (o_halted) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk1("halt_entered", o_halted, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
      chk1("halt_req_low", o_imem_req, 1'b0);
      chk1("halt_held", o_halted, 1'b1);
    end
    lat = 1;
    wcnt = 0;
    tick(1'b0, 1'b1, 16'h0010, 1'b0);
    chk1("unhalt", o_halted, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("unhalt_addr", o_imem_addr, 16'h0010);
    repeat (2) tick(1'b0, 1'b0, 16'h0000, 1'b0);

    // PC wrap from FFFE to 0000.
    tick(1'b0, 1'b1, 16'hFFFE, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (o_imem_req) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("wrap_fetch", o_imem_addr, 16'hFFFE);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_next_addr", o_imem_addr, 16'h0000);
    chk1("wrap_valid", o_instr_valid, 1'b1);
    chk("wrap_pc", o_instr_pc, 16'hFFFE);
    repeat (3) tick(1'b0, 1'b0, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of a fetch.
    chk1("pre_rst_req", o_imem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst_req", o_imem_req, 1'b0);
    chk("async_rst_addr", o_imem_addr, 16'h0000);
    chk1("async_rst_valid", o_instr_valid, 1'b0);
    chk1("async_rst_halted", o_halted, 1'b0);
    sb.delete();
    tb_squash = 0;
    wcnt = 0;
    i_imem_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_halt_in = 1'b0;
    i_stall_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o_imem_req) break;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("post_rst_addr", o_imem_addr, 16'h0000);
    repeat (4) tick(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
